// File: rtl/ram_pkg.sv
// Shared constants, state encoding and byte-mask helper for the RAM bank.
// Imported by ram_bank and ram_clear_seq.
package ram_pkg;

    localparam int BYTE      = 8;
    localparam int MAX_BYTES = 64;

    typedef logic [0:0] state_t;

    localparam state_t ST_CLEAR = 1'b0;
    localparam state_t ST_RUN   = 1'b1;

    // Expand per-byte enables into a per-bit mask; callers truncate to width.
    function automatic logic [MAX_BYTES*BYTE-1:0] bytemask(
        input logic [MAX_BYTES-1:0] be
    );
        logic [MAX_BYTES*BYTE-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            m[i*BYTE +: BYTE] = {BYTE{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks every word of the bank writing zero, then hands
// over to normal operation. A clr request restarts the walk from word 0.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int AWIDTH         = 8,
    parameter int MEMDEPTH       = 256,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter int IW             = (MEMDEPTH > 1) ? $clog2(MEMDEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    output state_t        state,
    output logic [IW-1:0] cnt,
    output logic          wipe,
    output logic          run_next
);

    localparam logic [IW-1:0] LAST = IW'(MEMDEPTH - 1);
    localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_t        state_n;
    logic [IW-1:0] cnt_n;

    // Next-state: clr always wins and restarts the walk at word 0.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (clr) begin
            state_n = ST_CLEAR;
            cnt_n   = '0;
        end else if (state == ST_CLEAR) begin
            if (cnt == LAST) begin
                state_n = ST_RUN;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    assign wipe     = (state == ST_CLEAR);
    assign run_next = (state_n == ST_RUN);

    // AWIDTH only documents the address space this sequencer serves.
    localparam int AW_UNUSED = AWIDTH;

endmodule

// File: rtl/ram_bank.sv
// Single-port synchronous RAM bank with valid/ready requests, byte write
// enables, range checking and a hardware clear sequencer.
module ram_bank
    import ram_pkg::*;
#(
    parameter int DWIDTH         = 32,
    parameter int AWIDTH         = 8,
    parameter int MEMDEPTH       = 256,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [AWIDTH-1:0]   req_addr,
    input  logic [DWIDTH/8-1:0] req_be,
    input  logic [DWIDTH-1:0]   req_wdata,
    output logic                rd_valid,
    output logic [DWIDTH-1:0]   rd_data,
    output logic                err,
    output logic                init_busy
);

    localparam int NB = DWIDTH / BYTE;
    localparam int IW = (MEMDEPTH > 1) ? $clog2(MEMDEPTH) : 1;
    localparam logic [AWIDTH:0] DEPTH = (AWIDTH + 1)'(MEMDEPTH);

    logic [DWIDTH-1:0] mem [MEMDEPTH];

    state_t           state;
    logic [IW-1:0]    cidx;
    logic             wipe;
    logic             run_next;
    logic             ready_q;
    logic [IW-1:0]    aidx;
    logic             in_range;
    logic             acc;
    logic             wr_ok;
    logic             rd_acc;
    logic [MAX_BYTES-1:0] be_ext;
    logic [DWIDTH-1:0]    mask;

    ram_clear_seq #(
        .AWIDTH         (AWIDTH),
        .MEMDEPTH       (MEMDEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET),
        .IW             (IW)
    ) u_seq (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .state    (state),
        .cnt      (cidx),
        .wipe     (wipe),
        .run_next (run_next)
    );

    assign aidx     = req_addr[IW-1:0];
    assign in_range = ({1'b0, req_addr} < DEPTH);
    assign acc      = req_valid && req_ready;
    assign wr_ok    = acc && req_we && in_range;
    assign rd_acc   = acc && !req_we;

    // Widen the byte enables to the helper's fixed width, then cut the mask.
    always_comb begin
        be_ext         = '0;
        be_ext[NB-1:0] = req_be;
        mask           = DWIDTH'(bytemask(be_ext));
    end

    // Ready is registered so it is low throughout reset in every config.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= run_next;
        end
    end

    assign req_ready = ready_q;
    assign init_busy = (state == ST_CLEAR);

    // Storage: clear walk has priority; writes merge only enabled bytes.
    always_ff @(posedge clk) begin
        if (wipe) begin
            mem[cidx] <= '0;
        end else if (wr_ok) begin
            mem[aidx] <= (mem[aidx] & ~mask) | (req_wdata & mask);
        end
    end

    // Read/err response registers; out-of-range reads return zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            err      <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            err      <= acc && !in_range;
            if (rd_acc) begin
                rd_data <= in_range ? mem[aidx] : '0;
            end
        end
    end

endmodule

// File: tb/tb_ram_bank.sv
// Directed bench for ram_bank: a 16-word bank and a 12-word bank with a
// 4-bit address, read results checked against a scoreboard queue.
module tb_ram_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_clr, a_valid, a_ready, a_we, a_rvalid, a_err, a_busy;
    logic [7:0]  a_addr;
    logic [3:0]  a_be;
    logic [31:0] a_wdata, a_rdata;

    logic        b_clr, b_valid, b_ready, b_we, b_rvalid, b_err, b_busy;
    logic [3:0]  b_addr;
    logic [3:0]  b_be;
    logic [31:0] b_wdata, b_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_a [16];
    logic [31:0] model_b [12];
    logic [31:0] exp_a [$];
    logic [31:0] exp_b [$];

    ram_bank #(
        .DWIDTH(32), .AWIDTH(8), .MEMDEPTH(16), .CLEAR_ON_RESET(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .clr(a_clr),
        .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
        .req_addr(a_addr), .req_be(a_be), .req_wdata(a_wdata),
        .rd_valid(a_rvalid), .rd_data(a_rdata), .err(a_err),
        .init_busy(a_busy)
    );

    ram_bank #(
        .DWIDTH(32), .AWIDTH(4), .MEMDEPTH(12), .CLEAR_ON_RESET(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .clr(b_clr),
        .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_addr(b_addr), .req_be(b_be), .req_wdata(b_wdata),
        .rd_valid(b_rvalid), .rd_data(b_rdata), .err(b_err),
        .init_busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [7:0] addr, input logic [31:0] d,
                           input logic [3:0] be);
        a_valid = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = d; a_be = be;
        tick();
        a_valid = 1'b0; a_we = 1'b0;
        model_a[addr[3:0]] = merge(model_a[addr[3:0]], d, be);
    endtask

    task automatic a_read_issue(input logic [7:0] addr);
        a_valid = 1'b1; a_we = 1'b0; a_addr = addr;
        exp_a.push_back(model_a[addr[3:0]]);
    endtask

    task automatic a_chk_rd(input string tag);
        logic [31:0] e;
        chk1({tag, "_valid"}, a_rvalid, 1'b1);
        e = (exp_a.size() > 0) ? exp_a.pop_front() : 32'hxxxx_xxxx;
        chk({tag, "_data"}, a_rdata, e);
    endtask

    task automatic b_write(input logic [3:0] addr, input logic [31:0] d,
                           input logic [3:0] be);
        b_valid = 1'b1; b_we = 1'b1; b_addr = addr; b_wdata = d; b_be = be;
        tick();
        b_valid = 1'b0; b_we = 1'b0;
        if (addr < 4'd12) model_b[addr] = merge(model_b[addr], d, be);
    endtask

    task automatic b_read_issue(input logic [3:0] addr);
        b_valid = 1'b1; b_we = 1'b0; b_addr = addr;
        exp_b.push_back((addr < 4'd12) ? model_b[addr] : 32'h0);
    endtask

    task automatic b_chk_rd(input string tag);
        logic [31:0] e;
        chk1({tag, "_valid"}, b_rvalid, 1'b1);
        e = (exp_b.size() > 0) ? exp_b.pop_front() : 32'hxxxx_xxxx;
        chk({tag, "_data"}, b_rdata, e);
    endtask

    initial begin
        int  n;
        logic early;
        reset = 1'b1;
        a_clr = 1'b0; a_valid = 1'b0; a_we = 1'b0; a_addr = '0;
        a_be = '0; a_wdata = '0;
        b_clr = 1'b0; b_valid = 1'b0; b_we = 1'b0; b_addr = '0;
        b_be = '0; b_wdata = '0;
        foreach (model_a[i]) model_a[i] = '0;
        foreach (model_b[i]) model_b[i] = '0;

        #12;
        chk1("rst_busy", a_busy, 1'b1);
        chk1("rst_ready", a_ready, 1'b0);
        chk1("rst_rvalid", a_rvalid, 1'b0);
        chk("rst_rdata", a_rdata, 32'h0);
        chk1("rst_err", a_err, 1'b0);

        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (!a_ready && n < 100) begin
            tick();
            n++;
        end
        chk("init_edges", n, 32'd16);
        chk1("init_busy_done", a_busy, 1'b0);

        a_read_issue(8'd5);
        tick();
        a_valid = 1'b0;
        a_chk_rd("rd5");
        tick();
        chk1("rd5_pulse", a_rvalid, 1'b0);

        a_write(8'd3, 32'hDEAD_BEEF, 4'b1111);
        chk1("wr_no_rvalid", a_rvalid, 1'b0);
        a_write(8'd3, 32'h1122_3344, 4'b0101);
        a_read_issue(8'd3);
        tick();
        a_valid = 1'b0;
        chk("be_merge_const", a_rdata, 32'hDE22_BE44);
        a_chk_rd("be_merge");

        a_write(8'd3, 32'hFFFF_FFFF, 4'b0000);
        chk1("be0_err", a_err, 1'b0);
        a_read_issue(8'd3);
        tick();
        a_valid = 1'b0;
        a_chk_rd("be0_keep");

        a_write(8'd0, 32'hA, 4'hF);
        a_write(8'd1, 32'hB, 4'hF);
        a_write(8'd2, 32'hC, 4'hF);
        a_read_issue(8'd0);
        tick();
        a_chk_rd("b2b0");
        a_read_issue(8'd1);
        tick();
        a_chk_rd("b2b1");
        a_read_issue(8'd2);
        tick();
        a_valid = 1'b0;
        a_chk_rd("b2b2");
        tick();
        chk1("b2b_end", a_rvalid, 1'b0);

        b_write(4'd1, 32'h1234_5678, 4'hF);
        b_write(4'd11, 32'hCAFE_F00D, 4'hF);
        b_write(4'd13, 32'hFFFF_FFFF, 4'hF);
        chk1("oor_wr_err", b_err, 1'b1);
        chk1("oor_wr_rvalid", b_rvalid, 1'b0);
        tick();
        chk1("oor_err_pulse", b_err, 1'b0);
        b_read_issue(4'd1);
        tick();
        b_valid = 1'b0;
        b_chk_rd("oor_alias");
        chk1("inr_rd_err", b_err, 1'b0);
        b_read_issue(4'd11);
        tick();
        b_read_issue(4'd14);
        b_chk_rd("last_word");
        tick();
        b_valid = 1'b0;
        b_chk_rd("oor_rd");
        chk1("oor_rd_err", b_err, 1'b1);

        a_write(8'd7, 32'hFFFF_FFFF, 4'hF);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk1("clr_ready", a_ready, 1'b0);
        chk1("clr_busy", a_busy, 1'b1);
        foreach (model_a[i]) model_a[i] = '0;
        n = 0;
        repeat (3) begin
            tick();
            n++;
        end
        a_clr = 1'b1;
        tick();
        n++;
        a_clr = 1'b0;
        a_read_issue(8'd7);
        early = 1'b0;
        while (!a_ready && n < 200) begin
            tick();
            n++;
            if (a_rvalid) early = 1'b1;
        end
        chk("clr_edges", n, 32'd20);
        chk1("held_no_early", early, 1'b0);
        tick();
        a_valid = 1'b0;
        a_chk_rd("held_rd7");

        a_write(8'd5, 32'h5A5A_5A5A, 4'hF);
        a_read_issue(8'd5);
        tick();
        a_valid = 1'b0;
        a_chk_rd("pre_rst");
        #2;
        reset = 1'b1;
        #1;
        chk1("mid_rst_rvalid", a_rvalid, 1'b0);
        chk("mid_rst_rdata", a_rdata, 32'h0);
        chk1("mid_rst_busy", a_busy, 1'b1);
        chk1("mid_rst_ready", a_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        foreach (model_a[i]) model_a[i] = '0;
        n = 0;
        while (!a_ready && n < 100) begin
            tick();
            n++;
        end
        chk("reinit_edges", n, 32'd16);
        a_read_issue(8'd5);
        tick();
        a_valid = 1'b0;
        a_chk_rd("post_rst_rd5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
